// File: rtl/pdh_pkg.sv
// Shared PDH core types: command codes, DAC code width, ownership encoding,
// arbiter FSM states and the packed DAC word helper.
package pdh_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_SET_LED,
    CMD_SET_DAC
  } cmd_t;

  localparam int unsigned DAC_CODE_W = 14;

  localparam logic OWN_PS   = 1'b0;
  localparam logic OWN_LOOP = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } arb_state_t;

  function automatic logic [31:0] pack_dac(input logic [DAC_CODE_W-1:0] ch1,
                                           input logic [DAC_CODE_W-1:0] ch0);
    return {2'b00, ch1, 2'b00, ch0};
  endfunction

endpackage

// File: rtl/dac_write_arbiter_if.sv
// Handshake bundle of the DAC write arbiter: PS write port, loop stream in, DAC stream out.
interface dac_write_arbiter_if;
  logic        ps_req_i;
  logic        ps_sel_i;
  logic [13:0] ps_code_i;
  logic        ps_ack_o;
  logic        ps_err_o;
  logic [31:0] loop_tdata_i;
  logic        loop_tvalid_i;
  logic        loop_tready_o;
  logic [31:0] dac_tdata_o;
  logic        dac_tvalid_o;
  logic        dac_tready_i;

  modport slave (
    input  ps_req_i, ps_sel_i, ps_code_i, loop_tdata_i, loop_tvalid_i, dac_tready_i,
    output ps_ack_o, ps_err_o, loop_tready_o, dac_tdata_o, dac_tvalid_o
  );

  modport master (
    output ps_req_i, ps_sel_i, ps_code_i, loop_tdata_i, loop_tvalid_i, dac_tready_i,
    input  ps_ack_o, ps_err_o, loop_tready_o, dac_tdata_o, dac_tvalid_o
  );
endinterface

// File: rtl/dac_shadow_reg.sv
// One DAC channel shadow; only the current owner's write path can update it.
module dac_shadow_reg
  import pdh_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  own_i,
  input  logic                  ps_we_i,
  input  logic [DAC_CODE_W-1:0] ps_code_i,
  input  logic                  loop_we_i,
  input  logic [DAC_CODE_W-1:0] loop_code_i,
  output logic [DAC_CODE_W-1:0] code_o,
  output logic                  wr_o
);

  logic [DAC_CODE_W-1:0] code_q, code_d;

  always_comb begin
    code_d = code_q;
    wr_o   = 1'b0;
    if (own_i == OWN_LOOP) begin
      if (loop_we_i) begin
        code_d = loop_code_i;
        wr_o   = 1'b1;
      end
    end else if (ps_we_i) begin
      code_d = ps_code_i;
      wr_o   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign code_o = code_q;

endmodule

// File: rtl/dac_write_arbiter.sv
// Two-channel DAC output arbiter: PS/loop owned shadows, coalesced and rate-limited beats.
module dac_write_arbiter
  import pdh_pkg::*;
#(
  parameter int unsigned MIN_GAP = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            owner_i,
  dac_write_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]      beat_cnt_o
);

  localparam int unsigned GapW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(MIN_GAP);

  arb_state_t            state_q;
  logic                  dirty_q;
  logic [GapW-1:0]       gap_q;
  logic [31:0]           tdata_q;
  logic                  tvalid_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  tready_q;

  logic [DAC_CODE_W-1:0] sh0, sh1;
  logic                  wr0, wr1, any_wr, loop_we;
  logic                  unused_loop_bits;

  assign loop_we = bus.loop_tvalid_i & tready_q;
  assign any_wr  = wr0 | wr1;
  assign unused_loop_bits = ^{bus.loop_tdata_i[31:30], bus.loop_tdata_i[15:14]};

  dac_shadow_reg u_shadow_ch0 (
    .clk         (clk),
    .rst         (rst),
    .own_i       (owner_i[0]),
    .ps_we_i     (bus.ps_req_i & ~bus.ps_sel_i),
    .ps_code_i   (bus.ps_code_i),
    .loop_we_i   (loop_we),
    .loop_code_i (bus.loop_tdata_i[13:0]),
    .code_o      (sh0),
    .wr_o        (wr0)
  );

  dac_shadow_reg u_shadow_ch1 (
    .clk         (clk),
    .rst         (rst),
    .own_i       (owner_i[1]),
    .ps_we_i     (bus.ps_req_i & bus.ps_sel_i),
    .ps_code_i   (bus.ps_code_i),
    .loop_we_i   (loop_we),
    .loop_code_i (bus.loop_tdata_i[29:16]),
    .code_o      (sh1),
    .wr_o        (wr1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dirty_q    <= 1'b0;
      gap_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      beat_cnt_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      ack_q    <= bus.ps_req_i;
      err_q    <= bus.ps_req_i & owner_i[bus.ps_sel_i];
      unique case (state_q)
        IDLE: begin
          if (dirty_q && (gap_q == '0)) begin
            // Launch with pre-edge shadows; a write landing now re-arms dirty.
            tdata_q  <= pack_dac(sh1, sh0);
            tvalid_q <= 1'b1;
            dirty_q  <= any_wr;
            state_q  <= SEND;
          end else if (any_wr) begin
            dirty_q <= 1'b1;
          end
        end
        SEND: begin
          if (any_wr) dirty_q <= 1'b1;
          if (tvalid_q && bus.dac_tready_i) begin
            tvalid_q   <= 1'b0;
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            gap_q      <= GapLoad;
            state_q    <= (MIN_GAP > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (any_wr) dirty_q <= 1'b1;
          if (gap_q != '0) gap_q <= gap_q - GapW'(1);
          if ((gap_q == GapW'(1)) || (gap_q == '0)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ps_ack_o      = ack_q;
  assign bus.ps_err_o      = err_q;
  assign bus.loop_tready_o = tready_q;
  assign bus.dac_tdata_o   = tdata_q;
  assign bus.dac_tvalid_o  = tvalid_q;
  assign beat_cnt_o        = beat_cnt_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed bench for dac_write_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_dac_write_arbiter;
  import pdh_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  owner0, owner4;
  logic [15:0] cnt0, cnt4;
  int          checks;
  int          failures;

  dac_write_arbiter_if bus0 ();
  dac_write_arbiter_if bus4 ();

  dac_write_arbiter #(.MIN_GAP(0), .CNT_W(16)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .owner_i    (owner0),
    .bus        (bus0),
    .beat_cnt_o (cnt0)
  );

  dac_write_arbiter #(.MIN_GAP(4), .CNT_W(16)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .owner_i    (owner4),
    .bus        (bus4),
    .beat_cnt_o (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  owner;
    logic        req;
    logic        sel;
    logic [13:0] code;
    logic        lv;
    logic [31:0] ld;
    logic        e_ack;
    logic        e_err;
    logic        e_valid;
    logic [31:0] e_data;
    int          e_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus0.ps_req_i      = 1'b0;
    bus0.ps_sel_i      = 1'b0;
    bus0.ps_code_i     = '0;
    bus0.loop_tvalid_i = 1'b0;
    bus0.loop_tdata_i  = '0;
  endtask

  task automatic ps0(input logic sel, input logic [13:0] code);
    bus0.ps_req_i  = 1'b1;
    bus0.ps_sel_i  = sel;
    bus0.ps_code_i = code;
  endtask

  initial begin
    int pulses;
    int rises[$];
    logic prev;

    checks   = 0;
    failures = 0;
    owner0   = 2'b00;
    owner4   = 2'b11;
    idle0();
    bus0.dac_tready_i  = 1'b1;
    bus4.ps_req_i      = 1'b0;
    bus4.ps_sel_i      = 1'b0;
    bus4.ps_code_i     = '0;
    bus4.loop_tvalid_i = 1'b0;
    bus4.loop_tdata_i  = '0;
    bus4.dac_tready_i  = 1'b1;

    //         owner  req   sel   code      lv    ld            ack   err   vld   data          cnt
    tbl[0]  = '{2'b00, 1'b1, 1'b0, 14'h0123, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h00000000, 0};
    tbl[1]  = '{2'b00, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h00000123, 0};
    tbl[2]  = '{2'b00, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h00000123, 1};
    tbl[3]  = '{2'b00, 1'b1, 1'b1, 14'h1ABC, 1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 32'h00000123, 1};
    tbl[4]  = '{2'b00, 1'b1, 1'b0, 14'h0005, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 32'h1ABC0123, 1};
    tbl[5]  = '{2'b00, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h1ABC0123, 2};
    tbl[6]  = '{2'b00, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h1ABC0005, 2};
    tbl[7]  = '{2'b00, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h1ABC0005, 3};
    tbl[8]  = '{2'b01, 1'b1, 1'b0, 14'h0777, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 32'h1ABC0005, 3};
    tbl[9]  = '{2'b01, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h1ABC0005, 3};
    tbl[10] = '{2'b01, 1'b0, 1'b0, 14'h0,    1'b1, 32'h3FFF2222, 1'b0, 1'b0, 1'b0, 32'h1ABC0005, 3};
    tbl[11] = '{2'b01, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h1ABC2222, 3};
    tbl[12] = '{2'b01, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h1ABC2222, 4};
    tbl[13] = '{2'b10, 1'b1, 1'b0, 14'h0042, 1'b1, 32'h00150FFF, 1'b1, 1'b0, 1'b0, 32'h1ABC2222, 4};
    tbl[14] = '{2'b10, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h00150042, 4};
    tbl[15] = '{2'b10, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h00150042, 5};
    tbl[16] = '{2'b10, 1'b1, 1'b1, 14'h0999, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 32'h00150042, 5};
    tbl[17] = '{2'b10, 1'b0, 1'b0, 14'h0,    1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h00150042, 5};

    // Reset state
    rst = 1'b1;
    #3;
    chk("rst_valid", {31'd0, bus0.dac_tvalid_o}, 32'd0);
    chk("rst_data", bus0.dac_tdata_o, 32'd0);
    chk("rst_cnt", {16'd0, cnt0}, 32'd0);
    chk("rst_ack", {31'd0, bus0.ps_ack_o}, 32'd0);
    chk("rst_tready", {31'd0, bus0.loop_tready_o}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("tready_after_release", {31'd0, bus0.loop_tready_o}, 32'd1);
    chk("idle_valid", {31'd0, bus0.dac_tvalid_o}, 32'd0);

    // Per-cycle vector table, MIN_GAP=0, sink always ready
    for (int i = 0; i < 18; i++) begin
      owner0             = tbl[i].owner;
      bus0.ps_req_i      = tbl[i].req;
      bus0.ps_sel_i      = tbl[i].sel;
      bus0.ps_code_i     = tbl[i].code;
      bus0.loop_tvalid_i = tbl[i].lv;
      bus0.loop_tdata_i  = tbl[i].ld;
      step();
      chk($sformatf("v%0d_ack", i), {31'd0, bus0.ps_ack_o}, {31'd0, tbl[i].e_ack});
      chk($sformatf("v%0d_err", i), {31'd0, bus0.ps_err_o}, {31'd0, tbl[i].e_err});
      chk($sformatf("v%0d_valid", i), {31'd0, bus0.dac_tvalid_o}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_data", i), bus0.dac_tdata_o, tbl[i].e_data);
      chk($sformatf("v%0d_cnt", i), {16'd0, cnt0}, tbl[i].e_cnt);
      chk($sformatf("v%0d_tready", i), {31'd0, bus0.loop_tready_o}, 32'd1);
    end
    idle0();

    // No beat without a write
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus0.dac_tvalid_o) pulses++;
    end
    chk("no_spurious_beat", pulses, 0);

    // Backpressure and coalescing; first cycle also mixes PS and loop writes
    bus0.dac_tready_i  = 1'b0;
    owner0             = 2'b01;
    ps0(1'b1, 14'h1ABC);
    bus0.loop_tvalid_i = 1'b1;
    bus0.loop_tdata_i  = 32'h0000_0001;
    step();
    chk("bp_mix_ack", {30'd0, bus0.ps_ack_o, bus0.ps_err_o}, 32'd2);
    owner0             = 2'b00;
    bus0.loop_tvalid_i = 1'b0;
    ps0(1'b0, 14'd2);
    step();
    chk("bp_first_valid", {31'd0, bus0.dac_tvalid_o}, 32'd1);
    chk("bp_first_data", bus0.dac_tdata_o, 32'h1ABC0001);
    ps0(1'b0, 14'd3);
    step();
    chk("bp_held_ack", {31'd0, bus0.ps_ack_o}, 32'd1);
    idle0();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_stable%0d_valid", k), {31'd0, bus0.dac_tvalid_o}, 32'd1);
      chk($sformatf("bp_stable%0d_data", k), bus0.dac_tdata_o, 32'h1ABC0001);
      step();
    end
    bus0.dac_tready_i = 1'b1;
    step();
    chk("bp_hs_valid", {31'd0, bus0.dac_tvalid_o}, 32'd0);
    chk("bp_hs_cnt", {16'd0, cnt0}, 32'd6);
    step();
    chk("bp_follow_valid", {31'd0, bus0.dac_tvalid_o}, 32'd1);
    chk("bp_follow_data", bus0.dac_tdata_o, 32'h1ABC0003);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus0.dac_tvalid_o) pulses++;
    end
    chk("bp_single_followup", pulses, 0);
    chk("bp_cnt_plus2", {16'd0, cnt0}, 32'd7);

    // Rate limit with MIN_GAP=4 under continuous loop writes
    prev = 1'b0;
    bus4.loop_tvalid_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus4.loop_tdata_i = k;
      step();
      if (bus4.dac_tvalid_o && !prev) begin
        rises.push_back(k);
        chk($sformatf("gap_rise%0d_data", k), bus4.dac_tdata_o, k - 1);
      end
      prev = bus4.dac_tvalid_o;
    end
    bus4.loop_tvalid_i = 1'b0;
    chk("gap_rise_count", rises.size(), 7);
    for (int r = 1; r < rises.size(); r++) begin
      chk($sformatf("gap_interval%0d", r), rises[r] - rises[r-1], 6);
    end

    // Reset while a beat is pending
    bus0.dac_tready_i = 1'b0;
    ps0(1'b0, 14'h0100);
    step();
    idle0();
    step();
    chk("rs_pre_valid", {31'd0, bus0.dac_tvalid_o}, 32'd1);
    chk("rs_pre_data", bus0.dac_tdata_o, 32'h1ABC0100);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_valid", {31'd0, bus0.dac_tvalid_o}, 32'd0);
    chk("rs_data", bus0.dac_tdata_o, 32'd0);
    chk("rs_cnt", {16'd0, cnt0}, 32'd0);
    chk("rs_tready", {31'd0, bus0.loop_tready_o}, 32'd0);
    step();
    rst = 1'b0;
    bus0.dac_tready_i = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus0.dac_tvalid_o) pulses++;
    end
    chk("rs_no_beat_after", pulses, 0);
    chk("rs_tready_after", {31'd0, bus0.loop_tready_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_write_arbiter.md
Name: dac_write_arbiter

Overview:
- Owns the two-channel DAC AXI-Stream output of the PDH core.
- Arbitrates between two requesters:
  - PS register writes: the decoded CMD_SET_DAC path.
  - The lock-loop datapath: a streaming request.
- Per-channel ownership is set by configuration. The block keeps a 14-bit shadow per channel, coalesces updates, rate-limits output beats and emits packed words {2'b00, ch1[13:0], 2'b00, ch0[13:0]}.
- Sits between the command decoder / loop filter and the DAC interface.

Parameters:
- MIN_GAP, 0, minimum idle cycles between the end of one output handshake and the next dac_tvalid_o assertion.
- CNT_W, 16, width of the emitted-beat counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- owner_i  in  2  per-channel owner; bit0 = ch0, bit1 = ch1; 0 = PS, 1 = loop.
- ps_req_i  in  1  single-cycle PS write request.
- ps_sel_i  in  1  PS target channel; 0 = ch0 (lower), 1 = ch1 (upper).
- ps_code_i  in  14  PS code.
- ps_ack_o  out  1  one-cycle acknowledge of a PS request.
- ps_err_o  out  1  valid with ps_ack_o; 1 = target channel owned by loop, write dropped.
- loop_tdata_i  in  32  packed loop word; bits [29:16] = ch1, bits [13:0] = ch0; bits [31:30] and [15:14] ignored.
- loop_tvalid_i  in  1  loop word valid.
- loop_tready_o  out  1  loop ready.
- dac_tdata_o  out  32  packed DAC word.
- dac_tvalid_o  out  1  DAC word valid.
- dac_tready_i  in  1  DAC sink ready; tie high if the sink has no backpressure.
- beat_cnt_o  out  CNT_W  count of completed output handshakes; wraps.

Behaviour:
- Reset (async assert, sync release) sets:
  - both shadows 0, dirty 0, FSM IDLE, gap counter 0;
  - all outputs 0, including dac_tdata_o and beat_cnt_o;
  - loop_tready_o 0 in reset, 1 from the first clk edge after release; it then stays 1, because the shadows always accept.
- PS write, with ps_req_i high at edge N:
  - If the target channel's owner bit is 0: the shadow is updated at edge N and dirty is set.
  - ps_ack_o is high for the cycle after edge N.
  - ps_err_o = owner bit of the target channel, sampled at edge N.
  - ps_req_i held high means one write per cycle.
- Loop write, with loop_tvalid_i && loop_tready_o at edge N:
  - Each channel whose owner bit is 1 takes its field at edge N.
  - Dirty is set if any channel was written; channels owned by PS are unchanged.
- Simultaneous PS and loop writes in the same cycle:
  - Both apply to their owned channels.
  - The same channel can never be written twice, because ownership is exclusive.
- An owner_i change takes effect at the edge where it is sampled. Shadow values are retained across ownership changes.
- Output FSM:
  - IDLE → SEND at edge E when dirty=1 and gap counter = 0. At E: dac_tdata_o is loaded with the shadow values present before E, dirty is cleared and dac_tvalid_o goes to 1. A write landing at E re-sets dirty.
  - SEND: dac_tdata_o and dac_tvalid_o are held stable until dac_tvalid_o && dac_tready_i at an edge.
  - On that handshake: dac_tvalid_o → 0, beat_cnt_o increments, gap counter loads MIN_GAP, next state is GAP if MIN_GAP > 0, otherwise IDLE.
  - GAP: the gap counter decrements each cycle; at 0 the FSM goes to IDLE.
- Latency: a write at edge N gives dac_tvalid_o high in the cycle after edge N+1 when IDLE with gap 0, i.e. 2 cycles.
- Coalescing:
  - Any number of writes during SEND/GAP produce exactly one follow-up beat, carrying the latest shadows.
  - No beat is emitted without a preceding write.
- With MIN_GAP=0 and dac_tready_i=1, continuous writes give dac_tvalid_o high every other cycle: SEND, IDLE, SEND…
- beat_cnt_o wraps from all-ones to 0.
- Reset mid-SEND drops the pending beat and dirty; dac_tvalid_o falls immediately.

Decomposition:
- Package pdh_pkg:
  - cmd_t enum (CMD_IDLE, CMD_SET_LED, CMD_SET_DAC);
  - DAC_CODE_W=14;
  - owner encoding constants OWN_PS=0, OWN_LOOP=1;
  - FSM state enum arb_state_t {IDLE, SEND, GAP};
  - function pack_dac(ch1, ch0) returning the 32-bit word.
- One natural sub-module, dac_shadow_reg: a single-channel 14-bit shadow with owner-gated write muxing. It is instantiated twice.

Test Plan:
- Reset, owner=00, PS write ch0=0x0123 → ps_ack_o one pulse with ps_err_o=0; dac_tdata_o=0x00000123; exactly one tvalid pulse in a 20-cycle window; beat_cnt_o=1.
- PS write ch1=0x1ABC, then ch0=0x0005 → words 0x1ABC0123, then 0x1ABC0005; ch1 is preserved across the ch0 write.
- owner=01, PS write ch0=0x0777 → ps_err_o=1 and the word is unchanged. Then loop word 0x3FFF2222 → dac_tdata_o=0x1ABC2222; ch1 is ignored and bits [31:30]/[15:14] are dropped.
- dac_tready_i=0, three PS writes ch0=1, 2, 3 → the first word stays 0x1ABC0001 and stable. After tready=1: exactly one more beat with 0x1ABC0003; beat_cnt_o advances by 2.
- MIN_GAP=4, loop_tvalid_i continuous → consecutive tvalid rising edges are 6 cycles apart.
- Assert rst while dac_tvalid_o=1 → dac_tvalid_o=0 and dac_tdata_o=0 in the same cycle; no beat after release without a new write.
